aes128_key_expand: RTL and testbench

Sequential AES-128 key schedule. Accepts one 128-bit cipher key and emits the 11 round keys (rk0..rk10) in order over a valid/ready stream. It sits directly downstream of the team's byte S-box: it instantiates the combinational `sbox` block (8-bit `pi0` -> `po0`) for SubWord and feeds round keys to the round datapath. The S-box is time-multiplexed to trade area for latency.

---
 rtl/aes_pkg.sv | 15 +
 rtl/sbox.sv | 27 ++
 rtl/aes128_key_expand.sv | 101 ++++++++++
 tb/tb_aes128_key_expand.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, key-expansion FSM states and word helpers
package aes_pkg;
  localparam int AES_WORD_W = 32;
  localparam int AES_BLK_W = 128;
  localparam int AES128_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  typedef enum logic [1:0] {IDLE, EMIT, SUB, MIX} ke_state_e;
  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/sbox.sv
// sbox: combinational AES forward S-box
//   pi0 : input byte
//   po0 : substituted byte
module sbox (
  input  logic [7:0] pi0,
  output logic [7:0] po0
);
  localparam logic [0:255][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign po0 = TBL[pi0];
endmodule

// File: rtl/aes128_key_expand.sv
// aes128_key_expand: sequential AES-128 key schedule, rk0..rk10 over valid/ready
//   key_valid/key_ready/key : cipher key in, accepted only in IDLE
//   rk_valid/rk_ready/rk    : round key out, rk_idx = 0..10
//   busy                    : high whenever not IDLE
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [AES_BLK_W-1:0] key,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_BLK_W-1:0] rk,
  output logic [3:0]           rk_idx,
  output logic                 busy
);
  localparam int N_SUB = 4 / NUM_SBOX;
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("NUM_SBOX must be 1, 2 or 4");
  end
  ke_state_e state_q, state_d;
  logic [AES_BLK_W-1:0] w_q, w_d;
  logic [0:3][7:0] t_q, t_d, rot;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] grp_q, grp_d;
  logic [AES_WORD_W-1:0] tp, n0, n1, n2, n3;
  logic [7:0] sb_i [NUM_SBOX];
  logic [7:0] sb_o [NUM_SBOX];
  logic [1:0] sel [NUM_SBOX];
  assign rot = rot_word(w_q[31:0]);
  // byte lane sel[i] of RotWord(w3) handled by instance i this group, MSB byte = lane 0
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    assign sel[i] = 2'(int'(grp_q) * NUM_SBOX + i);
    assign sb_i[i] = rot[sel[i]];
    sbox u_sbox (.pi0(sb_i[i]), .po0(sb_o[i]));
  end
  assign tp = t_q ^ {rcon_q, 24'h0};
  assign n0 = w_q[127:96] ^ tp;
  assign n1 = w_q[95:64] ^ n0;
  assign n2 = w_q[63:32] ^ n1;
  assign n3 = w_q[31:0] ^ n2;
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    t_d = t_q;
    rcon_d = rcon_q;
    idx_d = idx_q;
    grp_d = grp_q;
    unique case (state_q)
      IDLE: if (key_valid) begin
        w_d = key;
        idx_d = '0;
        rcon_d = RCON_INIT;
        state_d = EMIT;
      end
      EMIT: if (rk_ready) begin
        state_d = (idx_q == 4'(AES128_NR)) ? IDLE : SUB;
        grp_d = '0;
      end
      SUB: begin
        for (int i = 0; i < NUM_SBOX; i++) t_d[sel[i]] = sb_o[i];
        grp_d = grp_q + 2'd1;
        state_d = (grp_q == 2'(N_SUB - 1)) ? MIX : SUB;
      end
      MIX: begin
        w_d = {n0, n1, n2, n3};
        idx_d = idx_q + 4'd1;
        rcon_d = xtime(rcon_q);
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q <= '0;
      t_q <= '0;
      rcon_q <= RCON_INIT;
      idx_q <= '0;
      grp_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      t_q <= t_d;
      rcon_q <= rcon_d;
      idx_q <= idx_d;
      grp_q <= grp_d;
    end
  end
  assign key_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk = w_q;
  assign rk_idx = idx_q;
endmodule

// File: tb/tb_aes128_key_expand.sv
// tb_aes128_key_expand: randomized checks of the key schedule against a FIPS-197 model
module tb_aes128_key_expand;
  logic clk = 1'b0;
  logic rst_n;
  logic kv [3];
  logic kr [3];
  logic rv [3];
  logic rr [3];
  logic bz [3];
  logic [127:0] kd [3];
  logic [127:0] rk [3];
  logic [3:0] ri [3];
  logic [7:0] sbt [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got [11];
  int nvec = 0;
  int nerr = 0;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes128_key_expand #(.NUM_SBOX(4 >> g)) u_dut (
      .clk(clk), .rst_n(rst_n), .key_valid(kv[g]), .key_ready(kr[g]), .key(kd[g]),
      .rk_valid(rv[g]), .rk_ready(rr[g]), .rk(rk[g]), .rk_idx(ri[g]), .busy(bz[g])
    );
  end
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_key(input int d, input logic [127:0] k, input int duty, input bit jam);
    int cyc, bub, st, nsub;
    bit hs;
    nsub = 1 << d;
    model(k);
    bub = 0;
    while (kr[d] !== 1'b1 && bub < 50) begin
      step();
      bub++;
    end
    nvec++;
    if (kr[d] !== 1'b1) begin
      nerr++;
      $display("FAIL key_ready_wait dut%0d: got %b want 1", d, kr[d]);
      return;
    end
    kv[d] = 1'b1;
    kd[d] = k;
    step();
    kv[d] = jam;
    kd[d] = rnd128();
    cyc = 1;
    for (int i = 0; i <= 10; i++) begin
      bub = 0;
      while (rv[d] !== 1'b1 && bub < 20) begin
        nvec++;
        if (kr[d] !== 1'b0) begin
          nerr++;
          $display("FAIL key_ready_in_bubble dut%0d idx%0d: got %b want 0", d, i, kr[d]);
        end
        step();
        bub++;
        cyc++;
        if (jam) kd[d] = rnd128();
      end
      nvec++;
      if (bub != (i == 0 ? 0 : nsub + 1)) begin
        nerr++;
        $display("FAIL gap dut%0d idx%0d: got %0d want %0d", d, i, bub, (i == 0 ? 0 : nsub + 1));
        if (bub >= 20) return;
      end
      if (i == 10 && duty >= 100) begin
        nvec++;
        if (cyc != 1 + 10 * (nsub + 2)) begin
          nerr++;
          $display("FAIL rk10_latency dut%0d: got %0d want %0d", d, cyc, 1 + 10 * (nsub + 2));
        end
      end
      st = 0;
      forever begin
        rr[d] = ($urandom_range(99) < duty);
        nvec++;
        if (rk[d] !== exp_rk[i] || ri[d] !== 4'(i)) begin
          nerr++;
          $display("FAIL rk dut%0d idx%0d: got %h/%0d want %h/%0d", d, i, rk[d], ri[d], exp_rk[i], i);
        end
        nvec++;
        if (kr[d] !== 1'b0 || bz[d] !== 1'b1 || rv[d] !== 1'b1) begin
          nerr++;
          $display("FAIL flags_emit dut%0d idx%0d: got kr%b bz%b rv%b want kr0 bz1 rv1", d, i, kr[d], bz[d], rv[d]);
        end
        got[i] = rk[d];
        hs = rr[d];
        step();
        cyc++;
        if (jam) kd[d] = rnd128();
        if (hs) break;
        st++;
        if (st > 300) begin
          nvec++;
          nerr++;
          $display("FAIL stall_timeout dut%0d idx%0d: got %0d cycles want <=300", d, i, st);
          rr[d] = 1'b0;
          return;
        end
      end
      rr[d] = 1'b0;
    end
    nvec++;
    if (kr[d] !== 1'b1 || bz[d] !== 1'b0 || rv[d] !== 1'b0) begin
      nerr++;
      $display("FAIL idle_after_rk10 dut%0d: got kr%b bz%b rv%b want kr1 bz0 rv0", d, kr[d], bz[d], rv[d]);
    end
    if (!jam) kv[d] = 1'b0;
  endtask
  task automatic check_const(input string name, input int i, input logic [127:0] want);
    nvec++;
    if (got[i] !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got[i], want);
    end
  endtask
  task automatic test_reset();
    nvec++;
    if (kr[0] !== 1'b1 || rv[0] !== 1'b0 || rk[0] !== '0 || ri[0] !== 4'd0 || bz[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: got kr%b rv%b rk%h idx%0d bz%b want kr1 rv0 rk0 idx0 bz0", kr[0], rv[0], rk[0], ri[0], bz[0]);
    end
  endtask
  task automatic test_fips();
    run_key(0, FIPS_KEY, 100, 1'b0);
    check_const("fips_rk0", 0, FIPS_KEY);
    check_const("fips_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    check_const("fips_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask
  task automatic test_zero();
    run_key(0, '0, 100, 1'b0);
    check_const("zero_rk1", 1, 128'h62636363626363636263636362636363);
    check_const("zero_rk10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
  endtask
  task automatic test_backpressure();
    run_key(0, FIPS_KEY, 30, 1'b0);
    check_const("bp_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    check_const("bp_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int n = 0; n < 3; n++) run_key(0, rnd128(), 30, 1'b0);
  endtask
  task automatic test_back_to_back();
    run_key(0, rnd128(), 60, 1'b1);
    run_key(0, rnd128(), 100, 1'b0);
  endtask
  task automatic test_reset_mid();
    int n = 0;
    kv[0] = 1'b1;
    kd[0] = rnd128();
    step();
    kv[0] = 1'b0;
    rr[0] = 1'b1;
    while (!(rv[0] === 1'b1 && ri[0] === 4'd5) && n < 100) begin
      step();
      n++;
    end
    step();
    nvec++;
    if (bz[0] !== 1'b1 || rv[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reach_sub_idx5: got bz%b rv%b want bz1 rv0", bz[0], rv[0]);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (kr[0] !== 1'b1 || rv[0] !== 1'b0 || rk[0] !== '0 || ri[0] !== 4'd0 || bz[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: got kr%b rv%b rk%h idx%0d bz%b want kr1 rv0 rk0 idx0 bz0", kr[0], rv[0], rk[0], ri[0], bz[0]);
    end
    rr[0] = 1'b0;
    step();
    rst_n = 1'b1;
    run_key(0, rnd128(), 100, 1'b0);
  endtask
  task automatic test_narrow();
    for (int d = 1; d < 3; d++) begin
      run_key(d, FIPS_KEY, 100, 1'b0);
      check_const("narrow_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
      check_const("narrow_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      run_key(d, rnd128(), 50, 1'b0);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) sbt[i] = calc_sbox(8'(i));
    for (int d = 0; d < 3; d++) begin
      kv[d] = 1'b0;
      rr[d] = 1'b0;
      kd[d] = '0;
    end
    rst_n = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_fips();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
